sdram_upload: RTL
=================

SDRAM_UPLOAD -- requirements
Module: sdram_upload

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 23'h000000: SDRAM word address of upload byte 0.
REQ-002 SHALL have parameter SIZE, default 32'h0001_0000: upload region length in bytes.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ioctl_upload  input  1  HPS upload session active.
REQ-006 SHALL have port ioctl_addr  input  25  byte address requested by HPS.
REQ-007 SHALL have port ioctl_rd  input  1  one-cycle byte read strobe.
REQ-008 SHALL have port ioctl_din  output  8  byte returned to HPS.
REQ-009 SHALL have port ioctl_wait  output  1  HPS stall; high while a fetch is pending.
REQ-010 SHALL have port sdram_addr  output  23  SDRAM word address.
REQ-011 SHALL have port sdram_req  output  1  SDRAM read request.
REQ-012 SHALL have ports sdram_ack, sdram_valid, sdram_ready  input  1 each: request accepted, read data valid, controller initialised.
REQ-013 SHALL have port sdram_dout  input  32  SDRAM read data.

Function
REQ-014 SHALL map a byte address to word address BASE_ADDR + ioctl_addr[24:2] (23-bit, wraps modulo 2^23) and byte lane ioctl_addr[1:0]; lane 0 = sdram_dout[7:0], lane 3 = sdram_dout[31:24].
REQ-015 SHALL implement FSM states IDLE, REQ, DATA.
REQ-016 SHALL, in IDLE, ignore ioctl_rd while ioctl_upload is low.
REQ-017 SHALL, on ioctl_rd with ioctl_addr >= SIZE, drive ioctl_din = 8'hFF on the next cycle, make no SDRAM access, and keep ioctl_wait low.
REQ-018 SHALL, on ioctl_rd that needs a fetch, latch the address, raise ioctl_wait on the next cycle, and go to REQ.
REQ-019 SHALL, in REQ, hold sdram_req high while sdram_ready is high, keep sdram_addr stable, and go to DATA on the cycle sdram_ack is high; sdram_req SHALL be low from the cycle after ack onward.
REQ-020 SHALL, in DATA, wait for sdram_valid, then capture sdram_dout and drive the selected lane on ioctl_din on the next cycle, drop ioctl_wait that same cycle, and return to IDLE.
REQ-021 SHALL ignore ioctl_rd strobes while in REQ or DATA.
REQ-022 SHALL hold ioctl_din stable between reads.
REQ-023 SHALL, on a rising edge of ioctl_upload, invalidate any cached word.
REQ-024 SHALL, if ioctl_upload falls mid-fetch, complete the SDRAM transaction, drop ioctl_wait, and return to IDLE.
REQ-025 SHALL, if sdram_ready is low, hold in REQ with sdram_req low until sdram_ready goes high.
REQ-026 SHALL treat ioctl_rd coincident with reset as not issued.

Reset
REQ-027 SHALL, on reset, set state=IDLE, sdram_req=0, ioctl_wait=0, ioctl_din=8'h00, sdram_addr=23'h0, and cache invalid.
REQ-028 SHALL, on reset asserted mid-fetch, abandon the fetch immediately, ignore any later ack/valid for it, and deassert ioctl_wait on the following cycle.

Configuration
REQ-029 SHALL, when macro UPLOAD_WORD_CACHE_EN is defined, retain the last fetched word and its word address; an in-range ioctl_rd hitting that word SHALL return the lane on the next cycle with no fetch and ioctl_wait low.
REQ-030 SHALL, when UPLOAD_WORD_CACHE_EN is undefined, fetch from SDRAM for every in-range ioctl_rd, with no cache registers.

Verification
REQ-031 SHALL cover: BASE_ADDR=23'h100, read ioctl_addr=5, SDRAM returns 32'hDDCCBBAA -> sdram_addr=23'h101, ioctl_din=8'hBB, ioctl_wait high only from strobe+1 until valid+1.
REQ-032 SHALL cover: with UPLOAD_WORD_CACHE_EN, reads 4,5,6,7 -> exactly one sdram_req/ack, bytes 8'hAA,8'hBB,8'hCC,8'hDD; without it -> four fetches, same bytes.
REQ-033 SHALL cover: SIZE=16, read ioctl_addr=16 -> ioctl_din=8'hFF next cycle, sdram_req never asserted, ioctl_wait low.
REQ-034 SHALL cover: sdram_ready low for 10 cycles after strobe -> sdram_req low for those cycles, then high until ack; data is correct.
REQ-035 SHALL cover: reset pulsed one cycle while in DATA, then valid arrives -> ioctl_wait=0, ioctl_din=8'h00, state IDLE, valid ignored.
REQ-036 SHALL cover: ioctl_upload toggled low then high between two reads of the same word -> second read fetches again even with cache enabled.

Source files
------------

// File: rtl/sdram_upload_if.sv
// HPS upload byte port plus SDRAM read port, bundled for sdram_upload.
// slave = the upload bridge's view, master = the surrounding HPS/SDRAM side.
interface sdram_upload_if;
    logic        ioctl_upload;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [22:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_valid;
    logic        sdram_ready;
    logic [31:0] sdram_dout;

    modport slave (
        input  ioctl_upload, ioctl_addr, ioctl_rd,
        output ioctl_din, ioctl_wait,
        output sdram_addr, sdram_req,
        input  sdram_ack, sdram_valid, sdram_ready, sdram_dout
    );

    modport master (
        output ioctl_upload, ioctl_addr, ioctl_rd,
        input  ioctl_din, ioctl_wait,
        input  sdram_addr, sdram_req,
        output sdram_ack, sdram_valid, sdram_ready, sdram_dout
    );
endinterface

// File: rtl/sdram_upload.sv
// HPS upload bridge: serves byte reads from a 32-bit SDRAM region (optional word cache: UPLOAD_WORD_CACHE_EN).
// Latency: out-of-range or cache hit 1 cycle; fetch 1 cycle after sdram_valid.
// Backpressure: ioctl_wait stalls HPS during a fetch; sdram_req held until ack, gated by sdram_ready.
module sdram_upload #(
    parameter logic [22:0] BASE_ADDR = 23'h000000,
    parameter logic [31:0] SIZE      = 32'h0001_0000
) (
    input  logic          clk,
    input  logic          reset,
    sdram_upload_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t      state;
    logic [22:0] word_addr;
    logic [1:0]  lane;
    logic [7:0]  din_q;
    logic        wait_q;
    logic        req_q;
    logic        upload_q;

    logic        upload_rise;
    logic        rd_go;
    logic        in_range;
    logic [22:0] rd_word;

    assign upload_rise = bus.ioctl_upload & ~upload_q;
    assign rd_go       = bus.ioctl_rd & bus.ioctl_upload;
    assign in_range    = {7'd0, bus.ioctl_addr} < SIZE;
    // Word address wraps modulo 2^23 by construction of the 23-bit sum.
    assign rd_word     = BASE_ADDR + bus.ioctl_addr[24:2];

    function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] l);
        return w[{l, 3'b000} +: 8];
    endfunction

`ifdef UPLOAD_WORD_CACHE_EN
    logic        cache_vld;
    logic [22:0] cache_addr;
    logic [31:0] cache_dat;
    logic        cache_hit;

    // A new upload session may see different SDRAM contents, so a rise never hits.
    assign cache_hit = cache_vld & ~upload_rise & (cache_addr == rd_word);

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_vld  <= 1'b0;
            cache_addr <= 23'h0;
            cache_dat  <= 32'h0;
        end else if (upload_rise) begin
            cache_vld <= 1'b0;
        end else if (state == DATA && bus.sdram_valid) begin
            cache_vld  <= 1'b1;
            cache_addr <= word_addr;
            cache_dat  <= bus.sdram_dout;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            wait_q    <= 1'b0;
            din_q     <= 8'h00;
            word_addr <= 23'h0;
            lane      <= 2'd0;
            upload_q  <= 1'b0;
        end else begin
            upload_q <= bus.ioctl_upload;
            case (state)
                IDLE: begin
                    if (rd_go) begin
                        if (!in_range) begin
                            din_q <= 8'hFF;
                        end
`ifdef UPLOAD_WORD_CACHE_EN
                        else if (cache_hit) begin
                            din_q <= lane_sel(cache_dat, bus.ioctl_addr[1:0]);
                        end
`endif
                        else begin
                            word_addr <= rd_word;
                            lane      <= bus.ioctl_addr[1:0];
                            wait_q    <= 1'b1;
                            req_q     <= bus.sdram_ready;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.sdram_ack) begin
                        req_q <= 1'b0;
                        state <= DATA;
                    end else begin
                        req_q <= bus.sdram_ready;
                    end
                end
                DATA: begin
                    if (bus.sdram_valid) begin
                        din_q  <= lane_sel(bus.sdram_dout, lane);
                        wait_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign bus.sdram_addr = word_addr;
    assign bus.sdram_req  = req_q;
endmodule
